profile_accumulator: RTL and testbench

Folding histogram stage directly downstream of time_phase_calculator. Consumes one bin_index per detected pulse and increments a per-bin count in a single-port-per-side synchronous RAM of NBINS words. On request it streams the folded profile, bin 0 to NBINS-1, over a valid/ready interface to profile_memory/peak_finder, then self-clears for the next fold.

---
 rtl/profile_pkg.sv | 18 +
 rtl/profile_ram.sv | 23 ++
 rtl/profile_accumulator.sv | 167 ++++++++++++++++
 tb/tb_profile_accumulator.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/profile_pkg.sv
// Shared defaults, FSM state encoding and data typedefs for the folding profile accumulator.
package profile_pkg;

    localparam int NBINS = 1024;
    localparam int BIN_W = 10;
    localparam int CNT_W = 32;

    typedef logic [BIN_W-1:0] bin_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        CLEAR,
        ACCUM,
        DRAIN,
        DUMP
    } state_t;

endpackage

// File: rtl/profile_ram.sv
// Simple dual-port histogram RAM: one write port, one read port, 1-cycle registered read.
// A read and a write to the same address in one cycle returns the old contents.
module profile_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/profile_accumulator.sv
// Folding histogram: per-bin read-modify-write accumulate, in-order streamed dump, self-clear.
// Build option PROFILE_ACC_SATURATE_EN makes per-bin counts saturate instead of wrapping.
module profile_accumulator #(
    parameter int NBINS = profile_pkg::NBINS,
    parameter int BIN_W = profile_pkg::BIN_W,
    parameter int CNT_W = profile_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bin_valid_i,
    input  logic [BIN_W-1:0] bin_index_i,
    output logic             bin_ready_o,
    input  logic             dump_start_i,
    output logic             dump_busy_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [BIN_W-1:0] out_bin_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_last_o,
    output logic [31:0]      total_pulses_o,
    output logic [15:0]      dropped_o
);
    import profile_pkg::*;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [BIN_W:0]     rd_ptr_q, rd_ptr_d;
    logic               out_vld_q, out_vld_d;
    logic [BIN_W-1:0]   out_bin_q, out_bin_d;
    logic               busy_q, busy_d;
    logic [31:0]        tot_q, tot_d;
    logic [15:0]        drop_q, drop_d;

    logic               s2_vld_q, s2_fwd_q;
    logic [BIN_W-1:0]   s2_bin_q;
    logic [CNT_W-1:0]   s2_fwd_val_q;

    logic               ram_we;
    logic [BIN_W-1:0]   ram_waddr, ram_raddr;
    logic [CNT_W-1:0]   ram_wdata, ram_rdata;
    logic [CNT_W-1:0]   base, inc_val;
    logic               bin_ready, accept, out_last, xfer;

    assign bin_ready = (state_q == ACCUM);
    assign accept    = bin_valid_i && bin_ready;
    assign out_last  = out_vld_q && (out_bin_q == BIN_W'(NBINS - 1));
    assign xfer      = out_vld_q && out_ready_i;

    // RAM read-during-write returns stale data, so a hit on the bin being written takes the new value.
    assign base = s2_fwd_q ? s2_fwd_val_q : ram_rdata;
`ifdef PROFILE_ACC_SATURATE_EN
    assign inc_val = (&base) ? base : base + CNT_W'(1);
`else
    assign inc_val = base + CNT_W'(1);
`endif

    profile_ram #(.DEPTH(NBINS), .AW(BIN_W), .DW(CNT_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        out_vld_d = 1'b0;
        out_bin_d = out_bin_q;
        busy_d    = busy_q;
        tot_d     = tot_q;
        drop_d    = drop_q;
        ram_we    = s2_vld_q;
        ram_waddr = s2_bin_q;
        ram_wdata = inc_val;
        ram_raddr = bin_index_i;

        if (bin_valid_i && !bin_ready && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

        unique case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_ptr_q;
                ram_wdata = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == BIN_W'(NBINS - 1)) begin
                    state_d = ACCUM;
                    busy_d  = 1'b0;
                end
            end
            ACCUM: begin
                if (accept) tot_d = tot_q + 32'd1;
                if (dump_start_i) begin
                    state_d = DRAIN;
                    busy_d  = 1'b1;
                end
            end
            DRAIN: begin
                // Only S2 can be in flight here and it commits this cycle.
                rd_ptr_d = '0;
                state_d  = DUMP;
            end
            DUMP: begin
                // The RAM output register is the holding stage: on stall, re-read the presented bin.
                if (!out_vld_q || out_ready_i) begin
                    if (!rd_ptr_q[BIN_W]) begin
                        ram_raddr = rd_ptr_q[BIN_W-1:0];
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                        out_vld_d = 1'b1;
                        out_bin_d = rd_ptr_q[BIN_W-1:0];
                    end
                end else begin
                    ram_raddr = out_bin_q;
                    out_vld_d = 1'b1;
                end
                if (xfer && out_last) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    tot_d     = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_ptr_q    <= '0;
            rd_ptr_q     <= '0;
            out_vld_q    <= 1'b0;
            out_bin_q    <= '0;
            busy_q       <= 1'b0;
            tot_q        <= '0;
            drop_q       <= '0;
            s2_vld_q     <= 1'b0;
            s2_fwd_q     <= 1'b0;
            s2_bin_q     <= '0;
            s2_fwd_val_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_vld_q    <= out_vld_d;
            out_bin_q    <= out_bin_d;
            busy_q       <= busy_d;
            tot_q        <= tot_d;
            drop_q       <= drop_d;
            s2_vld_q     <= accept;
            s2_fwd_q     <= accept && s2_vld_q && (s2_bin_q == bin_index_i);
            s2_bin_q     <= bin_index_i;
            s2_fwd_val_q <= inc_val;
        end
    end

    assign bin_ready_o    = bin_ready;
    assign dump_busy_o    = busy_q;
    assign out_valid_o    = out_vld_q;
    assign out_bin_o      = out_bin_q;
    assign out_count_o    = out_vld_q ? ram_rdata : '0;
    assign out_last_o     = out_last;
    assign total_pulses_o = tot_q;
    assign dropped_o      = drop_q;

endmodule

// File: tb/tb_profile_accumulator.sv
// Randomized self-checking bench for profile_accumulator (NBINS=16, CNT_W=8) against a count-array model.
module tb_profile_accumulator;
    localparam int NB = 16;
    localparam int BW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bin_valid_i = 1'b0;
    logic [BW-1:0] bin_index_i = '0;
    logic          bin_ready_o;
    logic          dump_start_i = 1'b0;
    logic          dump_busy_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [BW-1:0] out_bin_o;
    logic [CW-1:0] out_count_o;
    logic          out_last_o;
    logic [31:0]   total_pulses_o;
    logic [15:0]   dropped_o;

    int checks = 0;
    int failures = 0;
    int model [NB];
    int tot_exp = 0;
    int drop_exp = 0;

    always #5 clk = ~clk;

    profile_accumulator #(.NBINS(NB), .BIN_W(BW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .bin_valid_i    (bin_valid_i),
        .bin_index_i    (bin_index_i),
        .bin_ready_o    (bin_ready_o),
        .dump_start_i   (dump_start_i),
        .dump_busy_o    (dump_busy_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_bin_o      (out_bin_o),
        .out_count_o    (out_count_o),
        .out_last_o     (out_last_o),
        .total_pulses_o (total_pulses_o),
        .dropped_o      (dropped_o)
    );

    function automatic int exp_cnt(input int raw);
`ifdef PROFILE_ACC_SATURATE_EN
        return (raw > 255) ? 255 : raw;
`else
        return raw % 256;
`endif
    endfunction

    // Advance one cycle; the model sees what the DUT will sample at the coming edge.
    task automatic tick();
        if (!rst && bin_valid_i) begin
            if (bin_ready_o) begin
                model[bin_index_i] = model[bin_index_i] + 1;
                tot_exp++;
            end else if (drop_exp < 65535) begin
                drop_exp++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NB; i++) model[i] = 0;
        tot_exp = 0;
    endtask

    task automatic send(input int b);
        checks++;
        if (bin_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL send_ready bin=%0d got=%b want=1", b, bin_ready_o);
        end
        bin_valid_i = 1'b1;
        bin_index_i = BW'(b);
        tick();
    endtask

    task automatic wait_clear_after_reset();
        for (int k = 1; k <= NB; k++) begin
            tick();
            checks++;
            if (bin_ready_o !== (k == NB) || dump_busy_o !== 1'b0) begin
                failures++;
                $display("FAIL clear_len k=%0d ready=%b busy=%b want_ready=%b want_busy=0",
                         k, bin_ready_o, dump_busy_o, (k == NB));
            end
        end
    endtask

    // mode 0: out_ready high, 1: pattern 1,0,0,1, 2: random
    task automatic do_dump(input int mode);
        int idx, cyc, first, k;
        logic stall, r, v, l, hl;
        logic [BW-1:0] b, hb;
        logic [CW-1:0] c, hc;
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        idx = 0; cyc = 1; first = -1; stall = 1'b0;
        hb = '0; hc = '0; hl = 1'b0;
        while (idx < NB && cyc < 400) begin
            v = out_valid_o; b = out_bin_o; c = out_count_o; l = out_last_o;
            if (v && first < 0) first = cyc;
            checks++;
            if (dump_busy_o !== 1'b1 || bin_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL dump_flags cyc=%0d busy=%b ready=%b want busy=1 ready=0",
                         cyc, dump_busy_o, bin_ready_o);
            end
            if (stall) begin
                checks++;
                if (!v || b !== hb || c !== hc || l !== hl) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got v=%b bin=%0d cnt=%0d last=%b want v=1 bin=%0d cnt=%0d last=%b",
                             cyc, v, b, c, l, hb, hc, hl);
                end
            end
            case (mode)
                0: r = 1'b1;
                1: r = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready_i = r;
            stall = v && !r;
            hb = b; hc = c; hl = l;
            if (v && r) begin
                checks++;
                if (int'(b) != idx || int'(c) != exp_cnt(model[idx]) || l !== (idx == NB - 1)) begin
                    failures++;
                    $display("FAIL dump_word idx=%0d got bin=%0d cnt=%0d last=%b want bin=%0d cnt=%0d last=%b",
                             idx, b, c, l, idx, exp_cnt(model[idx]), (idx == NB - 1));
                end
                idx++;
            end
            tick();
            cyc++;
        end
        out_ready_i = 1'b0;
        checks++;
        if (idx < NB) begin
            failures++;
            $display("FAIL dump_timeout got words=%0d want %0d", idx, NB);
        end
        checks++;
        if (first < 1 || first > 4) begin
            failures++;
            $display("FAIL dump_latency got=%0d want 1..4", first);
        end
        clear_model();
        k = 0;
        while (!bin_ready_o && k < 64) begin
            checks++;
            if (dump_busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL clear_flags k=%0d busy=%b valid=%b want busy=1 valid=0", k, dump_busy_o, out_valid_o);
            end
            tick();
            k++;
        end
        checks++;
        if (k != NB || dump_busy_o !== 1'b0 || total_pulses_o !== 32'(tot_exp)) begin
            failures++;
            $display("FAIL post_clear cycles=%0d busy=%b total=%0d want cycles=%0d busy=0 total=%0d",
                     k, dump_busy_o, total_pulses_o, NB, tot_exp);
        end
    endtask

    task automatic check_total(input int want);
        checks++;
        if (total_pulses_o !== 32'(want)) begin
            failures++;
            $display("FAIL total_pulses got=%0d want=%0d", total_pulses_o, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bin_ready_o, dump_busy_o, out_valid_o, out_last_o} !== 4'b0 || out_bin_o !== '0 ||
            out_count_o !== '0 || total_pulses_o !== '0 || dropped_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs ready=%b busy=%b valid=%b last=%b bin=%0d cnt=%0d tot=%0d drop=%0d want all 0",
                     bin_ready_o, dump_busy_o, out_valid_o, out_last_o, out_bin_o, out_count_o,
                     total_pulses_o, dropped_o);
        end
        rst = 1'b0;
        wait_clear_after_reset();
        do_dump(0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) send(3);
        send(7);
        bin_valid_i = 1'b0;
        tick();
        check_total(5);
        do_dump(0);
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 10; i++) begin
            send(5);
            send(6);
        end
        bin_valid_i = 1'b0;
        tick();
        check_total(20);
        do_dump(0);
    endtask

    task automatic test_stall(input int mode);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) send(int'($urandom_range(0, NB - 1)));
            else begin
                bin_valid_i = 1'b0;
                tick();
            end
        end
        bin_valid_i = 1'b0;
        tick();
        check_total(tot_exp);
        do_dump(mode);
    endtask

    task automatic test_dropped();
        int drop_before;
        drop_before = drop_exp;
        bin_valid_i = 1'b1;
        bin_index_i = BW'(9);
        do_dump(0);
        for (int i = 0; i < 3; i++) tick();
        bin_valid_i = 1'b0;
        tick();
        checks++;
        if (dropped_o !== 16'(drop_exp) || drop_exp - drop_before < NB + 2) begin
            failures++;
            $display("FAIL dropped got=%0d want=%0d (before=%0d)", dropped_o, drop_exp, drop_before);
        end
        check_total(3);
        do_dump(2);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 300; i++) send(2);
        bin_valid_i = 1'b0;
        tick();
        check_total(300);
        do_dump(0);
    endtask

    task automatic test_reset_mid_dump();
        bit found;
        send(1); send(4); send(4); send(9);
        bin_valid_i = 1'b0;
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        out_ready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (out_valid_o && out_bin_o == BW'(9)) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL mid_dump_reach got=no bin 9 want bin 9 presented");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || bin_ready_o !== 1'b0 || dump_busy_o !== 1'b0 || dropped_o !== '0) begin
            failures++;
            $display("FAIL mid_dump_reset valid=%b ready=%b busy=%b drop=%0d want all 0",
                     out_valid_o, bin_ready_o, dump_busy_o, dropped_o);
        end
        out_ready_i = 1'b0;
        clear_model();
        drop_exp = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear_after_reset();
        check_total(0);
        do_dump(0);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_alternate();
        test_stall(1);
        test_stall(2);
        test_dropped();
        test_wrap();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
